// File: rtl/cla_adder_pipe_if.sv
// Streaming operand/result bus for cla_adder_pipe. The SUB signal exists only
// when ADDSUB_EN is defined.
interface cla_adder_pipe_if #(
    parameter int WIDTH = 16
);
    // Both sides use the same rule: a beat transfers on a rising edge where
    // VALID and READY are both 1. VALID must not depend on READY.
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
`ifdef ADDSUB_EN
    logic             SUB;
`endif
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] SUM;
    logic             COUT;
    logic             OVF;
    logic             ZERO;

    modport master (
        output IN_VALID, A, B, CIN,
`ifdef ADDSUB_EN
        output SUB,
`endif
        output OUT_READY,
        input  IN_READY, OUT_VALID, SUM, COUT, OVF, ZERO
    );

    modport slave (
        input  IN_VALID, A, B, CIN,
`ifdef ADDSUB_EN
        input  SUB,
`endif
        input  OUT_READY,
        output IN_READY, OUT_VALID, SUM, COUT, OVF, ZERO
    );
endinterface

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder built from 4-bit lookahead groups, latency
// WIDTH/(4*STAGE_GROUPS). Define ADDSUB_EN to add the SUB (A-B) request.
module cla_adder_pipe #(
    parameter int WIDTH        = 16,
    parameter int STAGE_GROUPS = 1
) (
    input logic             CLK,
    input logic             RST,
    cla_adder_pipe_if.slave bus
);
    localparam int NGROUPS = WIDTH / 4;
    localparam int NSTAGES = NGROUPS / STAGE_GROUPS;

    // Rank 0 holds the accepted operands; rank s (1..NSTAGES) holds the state
    // after stage s has resolved its groups. Rank NSTAGES drives the outputs.
    logic [NSTAGES:0] vld_q, vld_d;
    logic [NSTAGES:0] carry_q, carry_d;
    logic [WIDTH-1:0] a_q   [0:NSTAGES-1];
    logic [WIDTH-1:0] a_d   [0:NSTAGES-1];
    logic [WIDTH-1:0] b_q   [0:NSTAGES-1];
    logic [WIDTH-1:0] b_d   [0:NSTAGES-1];
    logic [WIDTH-1:0] sum_q [1:NSTAGES];
    logic [WIDTH-1:0] sum_d [1:NSTAGES];
    logic             msb_c_q, msb_c_d;
    logic             zero_q, zero_d;
`ifdef ADDSUB_EN
    logic [NSTAGES-1:0] sub_q, sub_d;
`endif

    logic             en;
    logic             c_t;
    logic [WIDTH-1:0] acc_t;
    logic [WIDTH-1:0] b_eff_t;
    logic [5:0]       r_t;

    // Returns {carry into bit 3, group carry out, 4 sum bits}.
    function automatic logic [5:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                        input logic ci);
        logic [3:0] p, g, c;
        logic       co;
        p    = a ^ b;
        g    = a & b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[3], co, p ^ c};
    endfunction

    always_comb begin
        en      = !vld_q[NSTAGES] || bus.OUT_READY;
        vld_d   = '0;
        carry_d = '0;
        msb_c_d = 1'b0;
        c_t     = 1'b0;
        acc_t   = '0;
        b_eff_t = '0;
        r_t     = '0;

        vld_d[0] = bus.IN_VALID;
        a_d[0]   = bus.A;
        b_d[0]   = bus.B;
`ifdef ADDSUB_EN
        sub_d      = '0;
        sub_d[0]   = bus.SUB;
        carry_d[0] = bus.SUB | bus.CIN;
`else
        carry_d[0] = bus.CIN;
`endif
        for (int s = 1; s < NSTAGES; s++) begin
            a_d[s] = a_q[s-1];
            b_d[s] = b_q[s-1];
`ifdef ADDSUB_EN
            sub_d[s] = sub_q[s-1];
`endif
        end

        for (int s = 1; s <= NSTAGES; s++) begin
            vld_d[s] = vld_q[s-1];
            c_t      = carry_q[s-1];
            acc_t    = (s == 1) ? '0 : sum_q[(s > 1) ? s - 1 : 1];
            b_eff_t  = b_q[s-1];
`ifdef ADDSUB_EN
            if (sub_q[s-1]) b_eff_t = ~b_q[s-1];
`endif
            for (int k = 0; k < STAGE_GROUPS; k++) begin
                r_t = cla4(a_q[s-1][4*((s-1)*STAGE_GROUPS+k) +: 4],
                           b_eff_t[4*((s-1)*STAGE_GROUPS+k) +: 4], c_t);
                acc_t[4*((s-1)*STAGE_GROUPS+k) +: 4] = r_t[3:0];
                c_t     = r_t[4];
                msb_c_d = r_t[5];
            end
            carry_d[s] = c_t;
            sum_d[s]   = acc_t;
        end
        zero_d = (sum_d[NSTAGES] == '0);
    end

    // A single enable freezes every rank, bubbles included, under back-pressure.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_q   <= '0;
            carry_q <= '0;
            msb_c_q <= 1'b0;
            zero_q  <= 1'b0;
            for (int i = 0; i < NSTAGES; i++) begin
                a_q[i]     <= '0;
                b_q[i]     <= '0;
                sum_q[i+1] <= '0;
            end
`ifdef ADDSUB_EN
            sub_q <= '0;
`endif
        end else if (en) begin
            vld_q   <= vld_d;
            carry_q <= carry_d;
            msb_c_q <= msb_c_d;
            zero_q  <= zero_d;
            for (int i = 0; i < NSTAGES; i++) begin
                a_q[i]     <= a_d[i];
                b_q[i]     <= b_d[i];
                sum_q[i+1] <= sum_d[i+1];
            end
`ifdef ADDSUB_EN
            sub_q <= sub_d;
`endif
        end
    end

    assign bus.IN_READY  = en;
    assign bus.OUT_VALID = vld_q[NSTAGES];
    assign bus.SUM       = sum_q[NSTAGES];
    assign bus.COUT      = carry_q[NSTAGES];
    assign bus.OVF       = msb_c_q ^ carry_q[NSTAGES];
    assign bus.ZERO      = zero_q;
endmodule

// File: tb/tb_cla_adder_pipe.sv
// Directed bench for cla_adder_pipe: a 16-bit/latency-4 instance and a
// 32-bit, two-groups-per-stage instance sharing clock and reset.
module tb_cla_adder_pipe;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passed = 0;
    logic [16:0] exp_q[$];

    cla_adder_pipe_if #(.WIDTH(16)) bus ();
    cla_adder_pipe_if #(.WIDTH(32)) wbus ();

    cla_adder_pipe #(.WIDTH(16), .STAGE_GROUPS(1)) dut (.CLK(clk), .RST(rst), .bus(bus));
    cla_adder_pipe #(.WIDTH(32), .STAGE_GROUPS(2)) dut_w (.CLK(clk), .RST(rst), .bus(wbus));

    always #5 clk = ~clk;

    // Presents one operand for exactly one edge; returns at the following negedge.
    task automatic drive_op(input logic [15:0] a, input logic [15:0] b, input logic ci);
        @(negedge clk);
        bus.IN_VALID = 1'b1;
        bus.A        = a;
        bus.B        = b;
        bus.CIN      = ci;
        @(negedge clk);
        bus.IN_VALID = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.IN_VALID = 1'b1;
        bus.A        = 16'h0001;
        bus.B        = 16'h0001;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.OUT_VALID, bus.COUT, bus.OVF, bus.ZERO} !== 4'b0000)
            $display("FAIL reset_flags got %b exp 0000",
                     {bus.OUT_VALID, bus.COUT, bus.OVF, bus.ZERO});
        else passed++;
        checks++;
        if (bus.SUM !== 16'h0000) $display("FAIL reset_sum got %h exp 0000", bus.SUM);
        else passed++;
        checks++;
        if (bus.IN_READY !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", bus.IN_READY);
        else passed++;
        rst          = 1'b0;
        bus.IN_VALID = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            checks++;
            if (bus.OUT_VALID !== 1'b0)
                $display("FAIL reset_no_accept cycle %0d got %b exp 0", j, bus.OUT_VALID);
            else passed++;
        end
    endtask

    task automatic test_carry();
        drive_op(16'hFFFF, 16'h0001, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.OUT_VALID !== 1'b0) $display("FAIL carry_early got %b exp 0", bus.OUT_VALID);
        else passed++;
        @(negedge clk);
        checks++;
        if ({bus.OUT_VALID, bus.COUT, bus.OVF, bus.ZERO} !== 4'b1101)
            $display("FAIL carry_flags got %b exp 1101",
                     {bus.OUT_VALID, bus.COUT, bus.OVF, bus.ZERO});
        else passed++;
        checks++;
        if (bus.SUM !== 16'h0000) $display("FAIL carry_sum got %h exp 0000", bus.SUM);
        else passed++;
    endtask

    task automatic test_overflow();
        drive_op(16'h7FFF, 16'h0001, 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if ({bus.OUT_VALID, bus.COUT, bus.OVF, bus.ZERO} !== 4'b1010)
            $display("FAIL ovf_flags got %b exp 1010",
                     {bus.OUT_VALID, bus.COUT, bus.OVF, bus.ZERO});
        else passed++;
        checks++;
        if (bus.SUM !== 16'h8000) $display("FAIL ovf_sum got %h exp 8000", bus.SUM);
        else passed++;
        drive_op(16'h1234, 16'h4321, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if ({bus.OUT_VALID, bus.COUT, bus.OVF, bus.ZERO} !== 4'b1000)
            $display("FAIL cin_flags got %b exp 1000",
                     {bus.OUT_VALID, bus.COUT, bus.OVF, bus.ZERO});
        else passed++;
        checks++;
        if (bus.SUM !== 16'h5556) $display("FAIL cin_sum got %h exp 5556", bus.SUM);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [0:7] = '{16'h0001, 16'h00FF, 16'h0F0F, 16'h8000,
                                  16'h1111, 16'hABCD, 16'hFFFF, 16'h7FFF};
        logic [15:0] vb [0:7] = '{16'h0002, 16'h0001, 16'hF0F0, 16'h8000,
                                  16'h2222, 16'h1234, 16'hFFFF, 16'h7FFF};
        logic        vc [0:7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [16:0] ve [0:7] = '{17'h00003, 17'h00100, 17'h10000, 17'h10000,
                                  17'h03333, 17'h0BE01, 17'h1FFFF, 17'h0FFFE};
        logic        exp_v;
        logic [16:0] want;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            exp_v = (j >= 5 && j <= 12);
            checks++;
            if (bus.OUT_VALID !== exp_v)
                $display("FAIL stream_valid cycle %0d got %b exp %b", j, bus.OUT_VALID, exp_v);
            else passed++;
            if (exp_v && bus.OUT_VALID === 1'b1 && exp_q.size() > 0) begin
                want = exp_q.pop_front();
                checks++;
                if ({bus.COUT, bus.SUM} !== want)
                    $display("FAIL stream_result cycle %0d got %h exp %h", j, {bus.COUT, bus.SUM}, want);
                else passed++;
            end
            if (j < 8) begin
                bus.IN_VALID = 1'b1;
                bus.A        = va[j];
                bus.B        = vb[j];
                bus.CIN      = vc[j];
                exp_q.push_back(ve[j]);
            end else begin
                bus.IN_VALID = 1'b0;
            end
        end
        checks++;
        if (exp_q.size() != 0) $display("FAIL stream_leftover got %0d exp 0", exp_q.size());
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [15:0] e [0:4] = '{16'h0002, 16'h0004, 16'h0006, 16'h0008, 16'h000A};
        logic        exp_v, exp_r;
        int          idx;
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            bus.OUT_READY = !(j >= 5 && j <= 7);
            bus.IN_VALID  = (j < 5);
            bus.A         = 16'(j + 1);
            bus.B         = 16'(j + 1);
            bus.CIN       = 1'b0;
            #1;
            exp_v = (j >= 5 && j <= 12);
            exp_r = !(j >= 5 && j <= 7);
            idx   = (j < 8) ? 0 : j - 8;
            checks++;
            if (bus.OUT_VALID !== exp_v)
                $display("FAIL bp_valid cycle %0d got %b exp %b", j, bus.OUT_VALID, exp_v);
            else passed++;
            checks++;
            if (bus.IN_READY !== exp_r)
                $display("FAIL bp_in_ready cycle %0d got %b exp %b", j, bus.IN_READY, exp_r);
            else passed++;
            if (exp_v) begin
                checks++;
                if (bus.SUM !== e[idx])
                    $display("FAIL bp_sum cycle %0d got %h exp %h", j, bus.SUM, e[idx]);
                else passed++;
            end
        end
        bus.OUT_READY = 1'b1;
    endtask

    task automatic test_reset_mid();
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            bus.IN_VALID = (j < 3);
            bus.A        = 16'h1111;
            bus.B        = 16'h2222;
            rst          = (j == 3);
            #1;
            if (j >= 4) begin
                checks++;
                if (bus.OUT_VALID !== 1'b0)
                    $display("FAIL rst_mid_valid cycle %0d got %b exp 0", j, bus.OUT_VALID);
                else passed++;
            end
            if (j == 4) begin
                checks++;
                if ({bus.SUM, bus.COUT, bus.OVF, bus.ZERO} !== 19'h0)
                    $display("FAIL rst_mid_outputs got %h exp 0", {bus.SUM, bus.COUT, bus.OVF, bus.ZERO});
                else passed++;
            end
        end
    endtask

    task automatic test_wide();
        @(negedge clk);
        wbus.IN_VALID = 1'b1;
        wbus.A        = 32'hFFFF_FFFF;
        wbus.B        = 32'h0000_0001;
        wbus.CIN      = 1'b0;
        @(negedge clk);
        wbus.IN_VALID = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (wbus.OUT_VALID !== 1'b0) $display("FAIL wide_early got %b exp 0", wbus.OUT_VALID);
        else passed++;
        @(negedge clk);
        checks++;
        if ({wbus.OUT_VALID, wbus.COUT, wbus.OVF, wbus.ZERO} !== 4'b1101)
            $display("FAIL wide_flags got %b exp 1101",
                     {wbus.OUT_VALID, wbus.COUT, wbus.OVF, wbus.ZERO});
        else passed++;
        checks++;
        if (wbus.SUM !== 32'h0) $display("FAIL wide_sum got %h exp 00000000", wbus.SUM);
        else passed++;
    endtask

`ifdef ADDSUB_EN
    task automatic test_addsub();
        bus.SUB = 1'b1;
        drive_op(16'h0005, 16'h0007, 1'b0);
        bus.SUB = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({bus.OUT_VALID, bus.COUT} !== 2'b10)
            $display("FAIL sub_flags got %b exp 10", {bus.OUT_VALID, bus.COUT});
        else passed++;
        checks++;
        if (bus.SUM !== 16'hFFFE) $display("FAIL sub_sum got %h exp fffe", bus.SUM);
        else passed++;
    endtask
`endif

    initial begin
        rst            = 1'b1;
        bus.IN_VALID   = 1'b0;
        bus.A          = '0;
        bus.B          = '0;
        bus.CIN        = 1'b0;
        bus.OUT_READY  = 1'b1;
        wbus.IN_VALID  = 1'b0;
        wbus.A         = '0;
        wbus.B         = '0;
        wbus.CIN       = 1'b0;
        wbus.OUT_READY = 1'b1;
`ifdef ADDSUB_EN
        bus.SUB  = 1'b0;
        wbus.SUB = 1'b0;
`endif
        test_reset();
        test_carry();
        test_overflow();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_wide();
`ifdef ADDSUB_EN
        test_addsub();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/cla_adder_pipe.md
# cla_adder_pipe

Parametrised, pipelined carry-lookahead adder built from 4-bit lookahead groups. Each group uses the same generate/propagate lookahead equations as the team's 4-bit CLA. Groups are chained across registered pipeline stages, so a WIDTH-bit add sustains one result per clock at a fixed latency. A valid/ready handshake on both sides lets the block sit between streaming datapath blocks, with global back-pressure.

## Interface
- WIDTH, 16, operand/sum width; must be a multiple of 4, minimum 4
- STAGE_GROUPS, 1, number of 4-bit groups resolved per pipeline stage; (WIDTH/4) must be divisible by STAGE_GROUPS
- Derived: NSTAGES = WIDTH/(4*STAGE_GROUPS), which is also the latency in cycles

- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- IN_VALID  input  1  operands present
- IN_READY  output  1  block accepts operands this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- CIN  input  1  carry in
- SUB  input  1  subtract request; only present when ADDSUB_EN is defined
- OUT_VALID  output  1  result present
- OUT_READY  input  1  downstream accepts result
- SUM  output  WIDTH  A+B+CIN, modulo 2^WIDTH
- COUT  output  1  carry out of MSB
- OVF  output  1  two's-complement overflow (carry into MSB XOR COUT)
- ZERO  output  1  SUM == 0

## Operation
- Group g covers bits [4g+3:4g]. p = A^B and g = A&B per bit. Group carries use full 4-bit lookahead from the group carry-in. Sum bit = p ^ c.
- Stage s resolves groups s*STAGE_GROUPS .. (s+1)*STAGE_GROUPS-1. Groups inside a stage ripple their group carry.
- At each stage boundary the following are registered:
  - inter-stage carry
  - completed sum bits
  - unconsumed operand bits
  - valid bit
  - the carry into the MSB, once the final group is computed
- Global enable EN = !OUT_VALID || OUT_READY.
  - IN_READY = EN.
  - All stage registers advance only when EN = 1. With EN = 0 the whole pipeline freezes, bubbles included.
- Transfer in: an operand is accepted on an edge where IN_VALID && IN_READY. If IN_VALID = 0 while EN = 1, a bubble (valid = 0) enters stage 0.
- Transfer out: a result is consumed on an edge where OUT_VALID && OUT_READY.
- SUM, COUT, OVF and ZERO are all registered in the final stage and held stable while OUT_VALID && !OUT_READY.
- Results exit in acceptance order. No reordering, no drop, no duplication.
- Arithmetic is unsigned modulo 2^WIDTH. COUT is the carry from bit WIDTH-1. OVF is meaningful for signed interpretation only.
- Reset: on any edge with RST = 1, all valid bits and all outputs clear. In-flight operations are discarded. RST overrides EN and input transfers.

## Timing
- Reset values: OUT_VALID=0, SUM=0, COUT=0, OVF=0, ZERO=0. IN_READY is combinational and equals 1 during and after reset, because OUT_VALID=0.
- Latency: operands accepted at edge k produce OUT_VALID=1 after edge k+NSTAGES, provided EN stayed 1. Each stalled cycle adds one cycle.
- Throughput: one result per cycle while OUT_READY=1.
- IN_READY depends combinationally on OUT_READY. There are no other combinational input-to-output paths.
- Critical path per stage: STAGE_GROUPS chained 4-bit lookahead groups.
- Simultaneous events:
  - With the output full and OUT_READY=1, a new input is accepted on the same edge that the output is consumed.
  - RST=1 together with IN_VALID=1 does not accept the operand.

## Configuration
- ADDSUB_EN defined:
  - SUB port exists.
  - When SUB=1 at acceptance, B is inverted and the effective carry-in is 1. CIN is ignored, giving SUM = A - B.
  - SUB is captured with the operands and travels down the pipeline.
  - COUT=1 means no borrow.
  - OVF uses the same carry-into-MSB XOR COUT rule.
- ADDSUB_EN undefined: no SUB port; add only.

## Test plan
WIDTH=16 and STAGE_GROUPS=1 (latency 4) unless stated otherwise.
- Carry propagation: A=FFFF, B=0001, CIN=0 → after 4 cycles SUM=0000, COUT=1, ZERO=1, OVF=0.
- Signed overflow: A=7FFF, B=0001, CIN=0 → SUM=8000, COUT=0, OVF=1, ZERO=0. Also A=1234, B=4321, CIN=1 → SUM=5556.
- Streaming: 8 back-to-back operands with OUT_READY=1 → 8 results on consecutive cycles starting 4 cycles after the first, in order, each matching a reference add.
- Back-pressure: OUT_READY=0 for 3 cycles while a result is valid → IN_READY=0, SUM held unchanged. On release, the next results follow with no loss or duplication.
- Reset mid-operation: RST=1 for one cycle with 3 operations in flight → next cycle OUT_VALID=0 and all outputs 0. No stale result emerges in the following 4 cycles.
- Config sweep with ADDSUB_EN defined:
  - A=0005, B=0007, SUB=1 → SUM=FFFE, COUT=0.
  - WIDTH=32, STAGE_GROUPS=2: A=FFFFFFFF, B=1 → SUM=0, COUT=1 after 4 cycles.
